// File: rtl/bcd_up_timer_pkg.sv
// Shared types and constants for the two-digit BCD up-timer.
//   BCD_MAX  - largest legal BCD digit
//   bcd_t    - one 4-bit BCD digit
//   ALARM_ON - led pattern driven once the target has been reached
//   bcd_ok() - true for a legal (0..9) digit
package bcd_up_timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       BCD_MAX  = 4'd9;
  localparam logic [9:0] ALARM_ON = 10'h3FF;

  function automatic logic bcd_ok(input bcd_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_up_timer_digit.sv
// One BCD digit, 0..9, with ripple carry.
//   CLOCK_50  in   clock
//   reset     in   async active-high reset
//   inc       in   advance one step this cycle
//   clr       in   synchronous clear to 0, wins over inc
//   value     out  current digit
//   carry_out out  digit wraps 9 -> 0 this cycle (value==9 && inc)
module bcd_digit
  import bcd_up_timer_pkg::*;
(
  input  logic CLOCK_50,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output bcd_t value,
  output logic carry_out
);

  assign carry_out = inc && (value == BCD_MAX);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)      value <= '0;
    else if (clr)   value <= '0;
    else if (inc)   value <= (value == BCD_MAX) ? bcd_t'(0) : value + bcd_t'(1);
  end

endmodule

// File: rtl/bcd_up_timer.sv
// Two-digit BCD elapsed-time counter (00 -> 99), one step per prescaled tick,
// with a sticky alarm when the count reaches a switch-set target.
//   CLOCK_50         in   system clock
//   reset            in   async active-high reset
//   enable           in   1 = run, 0 = pause (prescaler and digits frozen)
//   clear            in   sync clear, overrides enable
//   target0/target1  in   target units/tens digit (BCD; >9 never matches)
//   BCD0/BCD1        out  units/tens digit
//   tick             out  one-cycle strobe, high in the cycle the digits advance
//   done             out  WRAP=0 only: count stopped at 99
//   led              out  ALARM_ON once target reached, else 0
module bcd_up_timer
  import bcd_up_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter bit WRAP    = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  bcd_t       target0,
  input  bcd_t       target1,
  output bcd_t       BCD0,
  output bcd_t       BCD1,
  output logic       tick,
  output logic       done,
  output logic [9:0] led
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic          run, strobe, hold, step, carry0, carry1, reach_99, match;

  // done also freezes the prescaler so a stopped counter stays quiet.
  assign run    = enable && !clear && !done;
  assign strobe = run && (presc == PRESC_LAST);

  // With WRAP=0 the count must never step past 99; done normally stops the
  // prescaler first, this keeps the digits safe regardless.
  assign hold = !WRAP && (BCD1 == BCD_MAX) && (BCD0 == BCD_MAX);
  assign step = strobe && !hold;

  assign reach_99 = step && (BCD1 == BCD_MAX) && (BCD0 == BCD_MAX - bcd_t'(1));

  // tick marks the cycle holding the freshly stepped value, so comparing
  // the digits while tick is high tests exactly the new count.
  assign match = tick && bcd_ok(target0) && bcd_ok(target1) &&
                 (BCD0 == target0) && (BCD1 == target1);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)        presc <= '0;
    else if (clear)   presc <= '0;
    else if (run)     presc <= strobe ? '0 : presc + PW'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tick <= 1'b0;
      led  <= '0;
    end else if (clear) begin
      tick <= 1'b0;
      led  <= '0;
    end else begin
      tick <= step;
      if (match) led <= ALARM_ON;
    end
  end

  generate
    if (WRAP) begin : g_wrap
      assign done = 1'b0;
    end else begin : g_hold
      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)          done <= 1'b0;
        else if (clear)     done <= 1'b0;
        else if (reach_99)  done <= 1'b1;
      end
    end
  endgenerate

  bcd_digit u_units (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .inc       (step),
    .clr       (clear),
    .value     (BCD0),
    .carry_out (carry0)
  );

  bcd_digit u_tens (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .inc       (carry0),
    .clr       (clear),
    .value     (BCD1),
    .carry_out (carry1)
  );

  // The tens carry-out has no consumer: wrap and hold are handled above.
  logic unused_carry;
  assign unused_carry = carry1;

endmodule

// File: tb/tb_bcd_up_timer.sv
module tb_bcd_up_timer;
  localparam int DIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset, enable, clear;
  logic [3:0] target0, target1;
  logic [3:0] bcd0 [2];
  logic [3:0] bcd1 [2];
  logic       tick [2];
  logic       done [2];
  logic [9:0] led  [2];

  int checks = 0, passed = 0;

  // Reference model: index 0 = WRAP=1 instance, index 1 = WRAP=0 instance.
  int m_cnt [2], m_presc [2];
  bit m_tick [2], m_done [2], m_led [2];

  always #5 CLOCK_50 = ~CLOCK_50;

  bcd_up_timer #(.CLK_HZ(4), .TICK_HZ(1), .WRAP(1'b1)) dut_wrap (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clear(clear),
    .target0(target0), .target1(target1), .BCD0(bcd0[0]), .BCD1(bcd1[0]),
    .tick(tick[0]), .done(done[0]), .led(led[0]));

  bcd_up_timer #(.CLK_HZ(4), .TICK_HZ(1), .WRAP(1'b0)) dut_hold (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clear(clear),
    .target0(target0), .target1(target1), .BCD0(bcd0[1]), .BCD1(bcd1[1]),
    .tick(tick[1]), .done(done[1]), .led(led[1]));

  function automatic logic [19:0] exp_vec(int w);
    return {4'(m_cnt[w] / 10), 4'(m_cnt[w] % 10), m_tick[w], m_done[w],
            m_led[w] ? 10'h3FF : 10'h000};
  endfunction

  function automatic logic [19:0] dut_vec(int w);
    return {bcd1[w], bcd0[w], tick[w], done[w], led[w]};
  endfunction

  task automatic model_zero();
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = 0; m_presc[w] = 0; m_tick[w] = 0; m_done[w] = 0; m_led[w] = 0;
    end
  endtask

  // Elapsed-time model: count is an integer 0..99, one step per DIV enabled cycles.
  task automatic model_edge();
    int tgt;
    bit tok;
    tgt = int'(target1) * 10 + int'(target0);
    tok = (target0 < 10) && (target1 < 10);
    if (reset || clear) begin
      model_zero();
      return;
    end
    for (int w = 0; w < 2; w++) begin
      if (m_tick[w] && tok && m_cnt[w] == tgt) m_led[w] = 1;
      if (enable && !m_done[w]) begin
        if (m_presc[w] == DIV - 1) begin
          m_presc[w] = 0;
          m_tick[w]  = 1;
          m_cnt[w]   = (m_cnt[w] + 1) % 100;
          if (w == 1 && m_cnt[w] == 99) m_done[w] = 1;
        end else begin
          m_presc[w]++;
          m_tick[w] = 0;
        end
      end else begin
        m_tick[w] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    model_edge();
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; clear = 1'b0; target0 = 4'd0; target1 = 4'd0;
    #2;
    model_zero();
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (dut_vec(w) !== 20'h0) $display("FAIL reset_async w%0d: got %h want 00000", w, dut_vec(w));
      else passed++;
    end
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if (dut_vec(0) !== 20'h0) $display("FAIL reset_idle: got %h want 00000", dut_vec(0));
    else passed++;
  endtask

  task automatic test_first_tick();
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (tick[0] !== (i == 4)) $display("FAIL first_tick_c%0d: got %b want %b", i, tick[0], (i == 4));
      else passed++;
    end
    checks++;
    if ({bcd1[0], bcd0[0]} !== 8'h01) $display("FAIL first_step: got %h want 01", {bcd1[0], bcd0[0]});
    else passed++;
  endtask

  task automatic test_carry();
    int n = 0;
    while (m_cnt[0] != 9 && n < 200) begin cyc(); n++; end
    n = 0;
    while (!(m_tick[0] && m_cnt[0] == 10) && n < 10) begin cyc(); n++; end
    checks++;
    if (n >= 10) $display("FAIL carry_timeout: got no tick want tick");
    else if ({bcd1[0], bcd0[0], tick[0]} !== 9'h021)
      $display("FAIL carry_09_10: got %h/%b want 10/1", {bcd1[0], bcd0[0]}, tick[0]);
    else passed++;
  endtask

  task automatic test_alarm();
    int n = 0;
    do_clear();
    target1 = 4'd2; target0 = 4'd3;
    while (!(m_tick[0] && m_cnt[0] == 23) && n < 200) begin cyc(); n++; end
    checks++;
    if (n >= 200) $display("FAIL alarm_timeout: got no 23 want 23");
    else if ({bcd1[0], bcd0[0], led[0]} !== 18'h08C00)
      $display("FAIL alarm_pre: got %h led %h want 23 led 000", {bcd1[0], bcd0[0]}, led[0]);
    else passed++;
    cyc();
    checks++;
    if (led[0] !== 10'h3FF) $display("FAIL alarm_set: got %h want 3ff", led[0]);
    else passed++;
    target1 = 4'd5; target0 = 4'd0;
    repeat (8) cyc();
    checks++;
    if (led[0] !== 10'h3FF) $display("FAIL alarm_sticky: got %h want 3ff", led[0]);
    else passed++;
    do_clear();
    checks++;
    if (dut_vec(0) !== 20'h0) $display("FAIL alarm_clear: got %h want 00000", dut_vec(0));
    else passed++;
  endtask

  task automatic test_pause();
    bit seen = 0;
    do_clear();
    cyc(); cyc();
    enable = 1'b0;
    repeat (10) begin cyc(); if (tick[0] !== 1'b0) seen = 1; end
    checks++;
    if (seen) $display("FAIL pause_tick: got tick want none");
    else passed++;
    enable = 1'b1;
    cyc();
    checks++;
    if (tick[0] !== 1'b0) $display("FAIL resume_early: got %b want 0", tick[0]);
    else passed++;
    cyc();
    checks++;
    if ({bcd1[0], bcd0[0], tick[0]} !== 9'h003)
      $display("FAIL resume_tick: got %h/%b want 01/1", {bcd1[0], bcd0[0]}, tick[0]);
    else passed++;
  endtask

  task automatic test_wrap();
    int  n = 0;
    bit  wrapped = 0, led_done = 0, moved = 0;
    target1 = 4'd0; target0 = 4'd0;
    do_clear();
    repeat (6) cyc();
    checks++;
    if (led[0] !== 10'h0) $display("FAIL no_match_at_clear: got %h want 000", led[0]);
    else passed++;
    while (!m_done[1] && n < 500) begin cyc(); n++; end
    checks++;
    if (n >= 500) $display("FAIL wrap_timeout: got no 99 want 99");
    else if ({bcd1[1], bcd0[1], done[1], done[0]} !== 10'h266)
      $display("FAIL hold_reach_99: got %h done %b/%b want 99 done 1/0",
               {bcd1[1], bcd0[1]}, done[1], done[0]);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick[1] !== 1'b0 || {bcd1[1], bcd0[1]} !== 8'h99 || done[1] !== 1'b1) moved = 1;
      if (m_tick[0] && !wrapped) begin
        wrapped = 1;
        checks++;
        if ({bcd1[0], bcd0[0], done[0], tick[0]} !== 10'h001)
          $display("FAIL wrap_rollover: got %h done %b tick %b want 00 0 1",
                   {bcd1[0], bcd0[0]}, done[0], tick[0]);
        else passed++;
      end else if (wrapped && !led_done) begin
        led_done = 1;
        checks++;
        if (led[0] !== 10'h3FF) $display("FAIL wrap_alarm_00: got %h want 3ff", led[0]);
        else passed++;
      end
    end
    checks++;
    if (moved) $display("FAIL hold_idle: got %h tick %b want 99 tick 0", {bcd1[1], bcd0[1]}, tick[1]);
    else passed++;
    checks++;
    if (!led_done || led[1] !== 10'h0) $display("FAIL hold_no_alarm: got %h/%b want 000/1", led[1], led_done);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    target1 = 4'd9; target0 = 4'd8;
    do_clear();
    while (!(m_tick[0] && m_cnt[0] == 47) && n < 300) begin cyc(); n++; end
    repeat (3) cyc();
    checks++;
    if (n >= 300 || {bcd1[0], bcd0[0]} !== 8'h47)
      $display("FAIL reset_mid_setup: got %h want 47", {bcd1[0], bcd0[0]});
    else passed++;
    reset = 1'b1;
    #2;
    model_zero();
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (dut_vec(w) !== 20'h0) $display("FAIL reset_mid w%0d: got %h want 00000", w, dut_vec(w));
      else passed++;
    end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_clear_strobe();
    target1 = 4'd0; target0 = 4'd1;
    cyc(); cyc(); cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (dut_vec(w) !== 20'h0) $display("FAIL clear_strobe w%0d: got %h want 00000", w, dut_vec(w));
      else passed++;
    end
    cyc();
    checks++;
    if (led[0] !== 10'h0 || tick[0] !== 1'b0) $display("FAIL clear_strobe_after: got %h/%b want 000/0", led[0], tick[0]);
    else passed++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) begin
        target0 = 4'($urandom_range(0, ($urandom_range(0, 4) == 0) ? 15 : 9));
        target1 = 4'($urandom_range(0, ($urandom_range(0, 4) == 0) ? 15 : 9));
      end
      cyc();
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (dut_vec(w) !== exp_vec(w)) begin
          bad++;
          if (bad < 10) $display("FAIL random_c%0d_w%0d: got %h want %h", i, w, dut_vec(w), exp_vec(w));
        end else passed++;
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_carry();
    test_alarm();
    test_pause();
    test_wrap();
    test_reset_mid();
    test_clear_strobe();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
